// File: rtl/fsm_stim_ctrl.sv
// fsm_stim_ctrl: drives a serial bit pattern into a Mealy FSM under test and captures its response.
module fsm_stim_ctrl #(
    parameter int W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [W-1:0]           pattern,
    input  logic [$clog2(W+1)-1:0] len,
    input  logic                   fsm_y,
    output logic                   fsm_x,
    output logic                   fsm_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           resp,
    output logic [$clog2(W+1)-1:0] ones
);
    localparam int LW = $clog2(W + 1);
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    state_t        state;
    logic [W-1:0]  sr;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_eff;
    assign len_eff = (len == '0 || len > LW'(W)) ? LW'(W) : len;
    // reset masks the FSM-facing outputs immediately so the controlled FSM stays held while reset is high
    assign busy      = ~reset & (state != IDLE);
    assign done      = ~reset & (state == DONE);
    assign fsm_rst_n = ~reset & (state != CLR);
    assign fsm_x     = ~reset & (state == RUN) & sr[W-1];
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            resp  <= '0;
            ones  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= CLR;
                    sr    <= pattern;
                    cnt   <= len_eff;
                    resp  <= '0;
                    ones  <= '0;
                end
                CLR: state <= RUN;
                RUN: begin
                    resp  <= {resp[W-2:0], fsm_y};
                    ones  <= ones + LW'(fsm_y);
                    sr    <= {sr[W-2:0], 1'b0};
                    cnt   <= cnt - LW'(1);
                    state <= (cnt == LW'(1)) ? DONE : RUN;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fsm_stim_ctrl.md
FSM_STIM_CTRL -- requirements
Module: fsm_stim_ctrl

Interface
REQ-001 Parameter: W, default 8, maximum pattern/response length in bits (W >= 2).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock domain, sampled on rising edge of clock.
REQ-004 start  input  1  request to run one test sequence; sampled only in IDLE.
REQ-005 pattern  input  W  stimulus bits, sent MSB-first; captured when start is accepted.
REQ-006 len  input  $clog2(W+1)  number of bits to send; captured with pattern; 0 or >W means W.
REQ-007 fsm_y  input  1  serial output of the controlled Mealy FSM, combinational in its state and x_in.
REQ-008 fsm_x  output  1  serial stimulus to the FSM x_in.
REQ-009 fsm_rst_n  output  1  active-low reset to the FSM.
REQ-010 busy  output  1  high from acceptance of start until the DONE cycle inclusive.
REQ-011 done  output  1  single-cycle pulse when a sequence completes.
REQ-012 resp  output  W  captured fsm_y bits; first captured bit at resp[len_eff-1], unused upper bits 0.
REQ-013 ones  output  $clog2(W+1)  count of fsm_y=1 samples in the last sequence.

Function
REQ-014 States SHALL be IDLE, CLR, RUN, DONE; all outputs SHALL be registered or decoded from state only.
REQ-015 IDLE: start=1 -> CLR next cycle, latching pattern into shift register and len_eff; start=0 -> stay.
REQ-016 CLR lasts exactly one cycle: fsm_rst_n=0, fsm_x=0, resp and ones cleared to 0, bit counter loaded with len_eff; -> RUN.
REQ-017 RUN: fsm_rst_n=1, fsm_x = shift register MSB; each rising edge samples fsm_y into resp LSB (resp shifts left), increments ones if fsm_y=1, shifts pattern left, decrements counter.
REQ-018 RUN SHALL last exactly len_eff cycles, then -> DONE.
REQ-019 DONE lasts one cycle: done=1, busy=1, fsm_x=0; -> IDLE.
REQ-020 Latency: start accepted at edge k -> done high in cycle k+len_eff+2 (counting CLR cycle as k+1).
REQ-021 IDLE outputs: busy=0, done=0, fsm_x=0, fsm_rst_n=1; resp and ones SHALL hold last sequence results.
REQ-022 start asserted while busy SHALL be ignored; no queuing; start held high through DONE restarts only from IDLE (one idle cycle between runs).
REQ-023 pattern and len changes after acceptance SHALL have no effect on the running sequence.
REQ-024 ones SHALL never exceed len_eff; counter SHALL not wrap.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE regardless of state, including mid-RUN, aborting the sequence.
REQ-026 While reset=1: fsm_rst_n=0, fsm_x=0, busy=0, done=0; after reset resp=0, ones=0, shift register and counter 0.
REQ-027 First cycle after reset deasserts: IDLE with fsm_rst_n=1; start in that cycle SHALL be accepted.

Verification
REQ-028 Loopback (fsm_y=fsm_x), pattern=8'hB5, len=8, start one cycle -> busy 10 cycles, fsm_rst_n low 1 cycle, done pulse in cycle 10, resp=8'hB5, ones=5.
REQ-029 Loopback, pattern=8'hC0, len=3 -> fsm_x sequence 1,1,0; resp=8'h06, ones=2; done 5 cycles after acceptance.
REQ-030 len=0 and len=9 with pattern=8'hFF, fsm_y=1 -> both run 8 RUN cycles, resp=8'hFF, ones=8.
REQ-031 start pulsed during RUN and pattern changed mid-run -> single done, resp matches original pattern, no second sequence.
REQ-032 reset asserted in 4th RUN cycle -> next cycle IDLE, busy=0, done never pulses, fsm_rst_n=0 during reset, resp=0, ones=0.
REQ-033 Connected to the Mealy FSM with random patterns -> resp equals a reference model of that FSM from S0, every run.
